bonus_nibble_matcher: RTL and testbench
=======================================

Name: bonus_nibble_matcher

Overview:
- Loads a 16-bit cypher (four 4-bit nibbles) during synchronous reset.
- Then accepts a stream of 4-bit `compared` nibbles, one per rising edge of the `read` strobe.
- Flags `match` when the last four accepted nibbles equal the cypher, taken low nibble first.
- Keeps an 8-bit wrap-around running `sum` of all accepted nibbles.
- Standalone stream-checker leaf block driven by a host or input FSM.

Parameters:
- NIB_W, 4, width of one symbol (`compared` width).
- DEPTH, 4, number of symbols in the cypher; `cypher` width = NIB_W*DEPTH.
- SUM_W, 8, width of the `sum` accumulator.

Ports:
- clock  in  1  single system clock; all logic updates on the rising edge.
- reset  in  1  synchronous, active-high; while high, samples `cypher` and clears state.
- cypher  in  NIB_W*DEPTH (16)  key. Nibble [3:0] is the first expected symbol and [15:12] the last. Sampled only while reset=1.
- compared  in  NIB_W (4)  candidate symbol; sampled on the accept cycle.
- read  in  1  level strobe; only its 0->1 transition accepts a symbol. It may stay high for any number of cycles.
- match  out  1  registered; 1 while the four most recent accepted symbols equal the stored cypher.
- sum  out  SUM_W (8)  registered; modulo-256 sum of all accepted symbols since reset.

Behaviour:
- Interface rule: one clock; reset is synchronous and active-high; ports are named `clock` and `reset`.
- Reset cycle, i.e. any rising edge with reset=1:
  - key_q <= cypher;
  - history <= 0;
  - fill count <= 0;
  - match <= 0;
  - sum <= 0;
  - read_prev <= read, so a `read` held high across reset release is not an edge.
  - If reset lasts several cycles, the last sampled `cypher` wins.
- Edge detect: accept = read & ~read_prev; read_prev <= read every cycle.
- On an accept edge (reset=0):
  - history shifts in `compared` as the newest symbol; the oldest drops out.
  - fill <= min(fill+1, DEPTH).
  - sum <= sum + zero-extended `compared`, truncated to SUM_W (wraps 255->0 region).
  - match <= (next fill == DEPTH) && next history equals key_q. Comparison order: oldest symbol vs key[3:0] … newest vs key[15:12].
- Latency: `match` and `sum` reflect an accepted symbol one clock after the accepting edge, i.e. visible in the cycle after read rises.
- No accept (read low, held high, or falling): history, fill, sum and match all hold. `compared` changes are ignored.
- Overlapping occurrences are detected: the history slides, so a pattern can share symbols with a previous match.
- Fewer than DEPTH symbols accepted: match=0, even if the cypher contains zero nibbles.
- Reset mid-stream: discards history and sum; the next stream starts from fill=0.

Optional Feature:
- Macro BONUS_CLEAR_ON_MATCH_EN.
  - Defined: on the accept edge that produces match=1, the next-cycle fill is forced to 0 and history cleared (sum unaffected). `match` still pulses high for that result. Overlapping occurrences are therefore not reported.
  - Undefined (default): sliding-window behaviour as above.

Decomposition:
- Package bonus_pkg: NIB_W, DEPTH, SUM_W default localparams; typedef nibble_t (logic [NIB_W-1:0]); typedef key_t (nibble_t array [DEPTH]).
- One natural sub-module, bonus_rise_detect: read_prev register plus the accept pulse, with sync reset tracking the input.
- Shift window, comparator and accumulator stay in the top.

Test Plan:
- Nominal stream:
  - Stimulus: reset with cypher=16'b0110_0101_1010_1001. Set compared=6 with read low for 30 cycles. Then pulse read (2 cycles high each) with F,F,9,A,0,9,A,5,6.
  - Required: sum=0 during the idle period. match=0 after each of the first eight symbols. match=1 and sum=79 (0x4F) after the ninth.
- Held read: read high for 10 cycles with compared=5 -> exactly one accept; sum increases by 5.
- Short prefix: after reset, accept only A,5,6 with cypher 0x65A9 -> match stays 0; sum=21.
- Sum wrap: 18 accepts of F -> sum=14 (270 mod 256); match=0 for cypher 0x65A9.
- Overlap:
  - Stimulus: cypher=0x1111, accept 1 five times.
  - Required: match=1 after the 4th and 5th accepts. With BONUS_CLEAR_ON_MATCH_EN, match=1 after the 4th, then 0 after the 5th.
- Reset mid-stream: after 9,A,5 assert reset with cypher 0x65A9 and read held high -> no accept at release; then 6 alone gives match=0 and sum=6.

Source files
------------

// File: rtl/bonus_pkg.sv
// Shared widths and symbol types for the bonus nibble matcher.
package bonus_pkg;

  localparam int NIB_W = 4;
  localparam int DEPTH = 4;
  localparam int SUM_W = 8;

  typedef logic [NIB_W-1:0] nibble_t;
  typedef nibble_t key_t [DEPTH];

endpackage

// File: rtl/bonus_rise_detect.sv
// Rising-edge detector for a level strobe; the previous-level register keeps
// tracking the input during reset so a level held across release is not an edge.
module bonus_rise_detect (
  input  logic clock,
  input  logic reset,
  input  logic level_i,
  output logic rise_o
);

  logic level_prev_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      level_prev_q <= level_i;
    end else begin
      level_prev_q <= level_i;
    end
  end

  assign rise_o = level_i & ~level_prev_q;

endmodule

// File: rtl/bonus_nibble_matcher.sv
// Sliding-window nibble matcher with a wrap-around running sum.
// Optional BONUS_CLEAR_ON_MATCH_EN: a match empties the window so overlaps are not reported.
module bonus_nibble_matcher #(
  parameter int NIB_W = bonus_pkg::NIB_W,
  parameter int DEPTH = bonus_pkg::DEPTH,
  parameter int SUM_W = bonus_pkg::SUM_W
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NIB_W*DEPTH-1:0] cypher,
  input  logic [NIB_W-1:0]       compared,
  input  logic                   read,
  output logic                   match,
  output logic [SUM_W-1:0]       sum
);

  localparam int FILL_W = $clog2(DEPTH + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);

  logic                   accept;
  logic [NIB_W*DEPTH-1:0] key_q;
  logic [NIB_W-1:0]       hist_q [DEPTH];
  logic [NIB_W-1:0]       hist_d [DEPTH];
  logic [FILL_W-1:0]      fill_q, fill_d;
  logic                   match_q, match_d;
  logic [SUM_W-1:0]       sum_q, sum_d;
  logic                   hit;

  bonus_rise_detect u_rise (
    .clock   (clock),
    .reset   (reset),
    .level_i (read),
    .rise_o  (accept)
  );

  // hist_q[0] is the oldest symbol and lines up with key_q[NIB_W-1:0].
  always_comb begin
    hist_d  = hist_q;
    fill_d  = fill_q;
    match_d = match_q;
    sum_d   = sum_q;
    hit     = 1'b0;
    if (accept) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        hist_d[i] = hist_q[i+1];
      end
      hist_d[DEPTH-1] = compared;
      fill_d = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FILL_W'(1);
      sum_d  = sum_q + SUM_W'(compared);
      hit    = (fill_d == FILL_FULL);
      for (int i = 0; i < DEPTH; i++) begin
        if (hist_d[i] != key_q[i*NIB_W +: NIB_W]) begin
          hit = 1'b0;
        end
      end
      match_d = hit;
`ifdef BONUS_CLEAR_ON_MATCH_EN
      if (hit) begin
        fill_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
          hist_d[i] = '0;
        end
      end
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      key_q   <= cypher;
      fill_q  <= '0;
      match_q <= 1'b0;
      sum_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        hist_q[i] <= '0;
      end
    end else begin
      fill_q  <= fill_d;
      match_q <= match_d;
      sum_q   <= sum_d;
      hist_q  <= hist_d;
    end
  end

  assign match = match_q;
  assign sum   = sum_q;

endmodule

// File: tb/tb_bonus_nibble_matcher.sv
// Self-checking bench for bonus_nibble_matcher: directed stream cases plus a
// randomized stream scored against a queue-based model of the last four symbols.
module tb_bonus_nibble_matcher;

  logic        clock;
  logic        reset;
  logic [15:0] cypher;
  logic [3:0]  compared;
  logic        read;
  logic        match;
  logic [7:0]  sum;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [3:0] acc_q[$];
  logic [8:0] exp_q[$];
  int         key_m [4];
  int         model_sum;
  logic [8:0] last_exp;

  bonus_nibble_matcher dut (
    .clock    (clock),
    .reset    (reset),
    .cypher   (cypher),
    .compared (compared),
    .read     (read),
    .match    (match),
    .sum      (sum)
  );

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_accept(input logic [3:0] nib);
    bit hit;
    acc_q.push_back(nib);
    if (acc_q.size() > 4) void'(acc_q.pop_front());
    model_sum = (model_sum + int'(nib)) % 256;
    hit = (acc_q.size() == 4);
    for (int i = 0; i < 4; i++) begin
      if (hit && int'(acc_q[i]) != key_m[i]) hit = 1'b0;
    end
`ifdef BONUS_CLEAR_ON_MATCH_EN
    if (hit) acc_q.delete();
`endif
    exp_q.push_back({hit, 8'(model_sum)});
  endfunction

  // Called at a negedge; holds reset for n cycles, last cycle carries the real key.
  task automatic do_reset(input logic [15:0] cyph, input logic rd, input int n);
    reset = 1'b1;
    read  = rd;
    for (int k = 0; k < n; k++) begin
      cypher = (k == n - 1) ? cyph : 16'($urandom);
      @(negedge clock);
    end
    reset = 1'b0;
    cypher = 16'($urandom);
    for (int i = 0; i < 4; i++) key_m[i] = (int'(cyph) >> (4 * i)) & 15;
    acc_q.delete();
    model_sum = 0;
    last_exp  = '0;
    check("rst_match", match, 0);
    check("rst_sum", sum, 0);
  endtask

  // Called at a negedge with read low; raises read for hold cycles then drops it.
  task automatic pulse(input logic [3:0] nib, input int hold);
    read     = 1'b1;
    compared = nib;
    model_accept(nib);
    @(negedge clock);
    last_exp = exp_q.pop_front();
    check("acc_match", match, last_exp[8]);
    check("acc_sum", sum, last_exp[7:0]);
    for (int k = 1; k < hold; k++) begin
      compared = 4'($urandom_range(0, 15));
      @(negedge clock);
      check("hold_match", match, last_exp[8]);
      check("hold_sum", sum, last_exp[7:0]);
    end
    read = 1'b0;
    compared = 4'($urandom_range(0, 15));
    @(negedge clock);
    check("idle_match", match, last_exp[8]);
    check("idle_sum", sum, last_exp[7:0]);
  endtask

  logic [3:0] nom_seq [9];
  logic [15:0] rcyph;

  initial begin
    reset    = 1'b1;
    read     = 1'b0;
    compared = 4'h0;
    cypher   = 16'h0;
    model_sum = 0;
    last_exp  = '0;
    nom_seq = '{4'hF, 4'hF, 4'h9, 4'hA, 4'h0, 4'h9, 4'hA, 4'h5, 4'h6};
    @(negedge clock);

    // nominal stream, multi-cycle reset so the last cypher must win
    do_reset(16'h65A9, 1'b0, 3);
    compared = 4'h6;
    for (int k = 0; k < 30; k++) begin
      @(negedge clock);
      if (k % 10 == 9) begin
        check("idle0_sum", sum, 0);
        check("idle0_match", match, 0);
      end
    end
    for (int k = 0; k < 9; k++) begin
      pulse(nom_seq[k], 2);
      if (k < 8) check("nom_prefix_match", match, 0);
    end
    check("nom_match", match, 1);
    check("nom_sum", sum, 8'h4F);

    // held read: one accept over ten high cycles
    pulse(4'h5, 10);
    check("held_sum", sum, 84);

    // short prefix
    do_reset(16'h65A9, 1'b0, 1);
    pulse(4'hA, 2); pulse(4'h5, 2); pulse(4'h6, 1);
    check("prefix_match", match, 0);
    check("prefix_sum", sum, 21);

    // sum wrap
    do_reset(16'h65A9, 1'b0, 1);
    for (int k = 0; k < 18; k++) pulse(4'hF, 1 + (k % 3));
    check("wrap_sum", sum, 14);
    check("wrap_match", match, 0);

    // overlapping occurrences
    do_reset(16'h1111, 1'b0, 2);
    for (int k = 0; k < 4; k++) pulse(4'h1, 2);
    check("ovl4_match", match, 1);
    pulse(4'h1, 2);
`ifdef BONUS_CLEAR_ON_MATCH_EN
    check("ovl5_match", match, 0);
`else
    check("ovl5_match", match, 1);
`endif

    // reset mid-stream with read held high across release
    do_reset(16'h65A9, 1'b0, 1);
    pulse(4'h9, 2); pulse(4'hA, 2); pulse(4'h5, 2);
    do_reset(16'h65A9, 1'b1, 2);
    for (int k = 0; k < 3; k++) begin
      compared = 4'($urandom_range(0, 15));
      @(negedge clock);
      check("rel_sum", sum, 0);
      check("rel_match", match, 0);
    end
    read = 1'b0;
    @(negedge clock);
    pulse(4'h6, 2);
    check("mid_match", match, 0);
    check("mid_sum", sum, 6);

    // randomized stream over a two-symbol alphabet so matches are frequent
    rcyph = 16'h0;
    for (int i = 0; i < 4; i++) rcyph[4*i +: 4] = $urandom_range(0, 1) ? 4'h3 : 4'hC;
    do_reset(rcyph, 1'b0, 1);
    for (int t = 0; t < 200; t++) begin
      if ($urandom_range(0, 39) == 0) begin
        for (int i = 0; i < 4; i++) rcyph[4*i +: 4] = $urandom_range(0, 1) ? 4'h3 : 4'hC;
        do_reset(rcyph, 1'($urandom_range(0, 1)), $urandom_range(1, 3));
        read = 1'b0;
        @(negedge clock);
        check("rnd_rst_sum", sum, 0);
      end
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        compared = 4'($urandom_range(0, 15));
        @(negedge clock);
      end
      pulse($urandom_range(0, 1) ? 4'h3 : 4'hC, $urandom_range(1, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
